// File: rtl/regfile_wl_16x16.sv
// regfile_wl_16x16: 16-entry register file written by a one-hot wordline, two registered read ports with bypass
module regfile_wl_16x16 #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      wordline_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [3:0]       src_reg1_i,
  input  logic [3:0]       src_reg2_i,
  input  logic             rd_en_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] src_data1_o,
  output logic [WIDTH-1:0] src_data2_o,
  output logic             rd_valid_o,
  output logic [3:0]       last_wr_idx_o,
  output logic [7:0]       wr_count_o,
  output logic             wl_err_o
);
  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] src_data1_q, src_data2_q, rd1_d, rd2_d;
  logic             rd_valid_q, wl_err_q, wl_any, wl_onehot, wl_multi;
  logic [3:0]       last_wr_idx_q, wr_idx;
  logic [7:0]       wr_count_q;

  // Classify the wordline; x & (x-1) clears the lowest set bit, so zero means at most one bit
  assign wl_any    = |wordline_i;
  assign wl_onehot = wl_any && ((wordline_i & (wordline_i - 16'd1)) == 16'd0);
  assign wl_multi  = wl_any && !wl_onehot;

  // OR-encode the wordline; only meaningful when it is one-hot
  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < 16; i++) wr_idx = wr_idx | (wordline_i[i] ? i[3:0] : 4'd0);
  end

  // Read value with R0 forcing first, then same-cycle write bypass
  function automatic logic [WIDTH-1:0] rd_val(input logic [3:0] s);
    return (ZERO_R0 && s == 4'd0) ? '0 :
           (wl_onehot && s == wr_idx) ? write_data_i : regs_q[s];
  endfunction

  assign rd1_d = rd_val(src_reg1_i);
  assign rd2_d = rd_val(src_reg2_i);

  // Register array: accepted one-hot writes only, R0 left untouched when hardwired to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    else if (wl_onehot && !(ZERO_R0 && wr_idx == 4'd0)) regs_q[wr_idx] <= write_data_i;
  end

  // Read ports: load on request, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_data1_q <= '0;
      src_data2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        src_data1_q <= rd1_d;
        src_data2_q <= rd2_d;
      end
    end
  end

  // Write bookkeeping: last index, saturating count, sticky error where set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr_idx_q <= '0;
      wr_count_q    <= '0;
      wl_err_q      <= 1'b0;
    end else begin
      if (wl_onehot) last_wr_idx_q <= wr_idx;
      if (wl_onehot && wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
      wl_err_q <= wl_multi ? 1'b1 : clr_err_i ? 1'b0 : wl_err_q;
    end
  end

  assign src_data1_o   = src_data1_q;
  assign src_data2_o   = src_data2_q;
  assign rd_valid_o    = rd_valid_q;
  assign last_wr_idx_o = last_wr_idx_q;
  assign wr_count_o    = wr_count_q;
  assign wl_err_o      = wl_err_q;
endmodule

// File: tb/tb_regfile_wl_16x16.sv
// tb_regfile_wl_16x16: directed stimulus with a queue scoreboard for read results
module tb_regfile_wl_16x16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wordline_i = '0, write_data_i = '0;
  logic [3:0]  src_reg1_i = '0, src_reg2_i = '0;
  logic        rd_en_i = 1'b0, clr_err_i = 1'b0;
  logic [15:0] src_data1_o, src_data2_o;
  logic        rd_valid_o, wl_err_o;
  logic [3:0]  last_wr_idx_o;
  logic [7:0]  wr_count_o;
  int          tests = 0, fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  regfile_wl_16x16 #(.WIDTH(16), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wordline_i(wordline_i), .write_data_i(write_data_i),
    .src_reg1_i(src_reg1_i), .src_reg2_i(src_reg2_i), .rd_en_i(rd_en_i), .clr_err_i(clr_err_i),
    .src_data1_o(src_data1_o), .src_data2_o(src_data2_o), .rd_valid_o(rd_valid_o),
    .last_wr_idx_o(last_wr_idx_o), .wr_count_o(wr_count_o), .wl_err_o(wl_err_o)
  );

  always #5 clk = ~clk;

  // Monitor: every valid read result is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rd_valid_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected got=%h_%h expected no read result", src_data1_o, src_data2_o);
      end else begin
        exp_v = exp_q.pop_front();
        if ({src_data1_o, src_data2_o} !== exp_v) begin
          fails++;
          $display("FAIL rd_data got=%h_%h expected=%h_%h", src_data1_o, src_data2_o, exp_v[31:16], exp_v[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; a read pushes its expected pair before the edge
  task automatic step(input logic [15:0] wl, input logic [15:0] wd, input logic rd,
                      input logic [3:0] s1, input logic [3:0] s2, input logic clr,
                      input logic [15:0] e1, input logic [15:0] e2);
    wordline_i = wl; write_data_i = wd; rd_en_i = rd;
    src_reg1_i = s1; src_reg2_i = s2; clr_err_i = clr;
    if (rd) exp_q.push_back({e1, e2});
    @(posedge clk); #1;
    wordline_i = '0; write_data_i = '0; rd_en_i = 1'b0; clr_err_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_data", {src_data1_o, src_data2_o}, 32'd0);
    chk("rst_cnt", {24'd0, wr_count_o}, 32'd0);
    chk("rst_err", {31'd0, wl_err_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    // 1: reads after reset return zero
    step(16'h0, 16'h0, 1, 4'd3, 4'd15, 0, 16'h0, 16'h0);
    step(16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    // 2: write reg5 then read it
    step(16'h0020, 16'hBEEF, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    chk("t2_last", {28'd0, last_wr_idx_o}, 32'd5);
    chk("t2_cnt", {24'd0, wr_count_o}, 32'd1);
    step(16'h0, 16'h0, 1, 4'd5, 4'd3, 0, 16'hBEEF, 16'h0);
    step(16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    chk("hold_data", {src_data1_o, src_data2_o}, 32'hBEEF_0000);
    // 3: same-cycle write and read of reg8 on both ports
    step(16'h0100, 16'h1234, 1, 4'd8, 4'd8, 0, 16'h1234, 16'h1234);
    chk("t3_cnt", {24'd0, wr_count_o}, 32'd2);
    // 4: multi-hot rejected, never bypassed, sticky error
    step(16'h0080, 16'h7777, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    step(16'h0081, 16'hDEAD, 1, 4'd7, 4'd0, 0, 16'h7777, 16'h0);
    chk("t4_err", {31'd0, wl_err_o}, 32'd1);
    chk("t4_last", {28'd0, last_wr_idx_o}, 32'd7);
    chk("t4_cnt", {24'd0, wr_count_o}, 32'd3);
    step(16'h0, 16'h0, 1, 4'd0, 4'd7, 0, 16'h0, 16'h7777);
    repeat (10) step(16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    chk("t4_sticky", {31'd0, wl_err_o}, 32'd1);
    step(16'h0, 16'h0, 0, 4'd0, 4'd0, 1, 16'h0, 16'h0);
    chk("t4_clr", {31'd0, wl_err_o}, 32'd0);
    step(16'hC000, 16'h0, 0, 4'd0, 4'd0, 1, 16'h0, 16'h0);
    chk("set_wins", {31'd0, wl_err_o}, 32'd1);
    step(16'h0, 16'h0, 0, 4'd0, 4'd0, 1, 16'h0, 16'h0);
    chk("clr_again", {31'd0, wl_err_o}, 32'd0);
    // 5: R0 write counted but reads stay zero, overriding bypass
    step(16'h0001, 16'hFFFF, 1, 4'd0, 4'd7, 0, 16'h0, 16'h7777);
    chk("t5_last", {28'd0, last_wr_idx_o}, 32'd0);
    chk("t5_cnt", {24'd0, wr_count_o}, 32'd4);
    step(16'h8000, 16'hA5A5, 1, 4'd15, 4'd0, 0, 16'hA5A5, 16'h0);
    chk("t5_last15", {28'd0, last_wr_idx_o}, 32'd15);
    // 6: saturate the write counter
    for (int i = 0; i < 300; i++)
      step(16'h1 << (i % 16), 16'(i), 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    chk("t6_sat", {24'd0, wr_count_o}, 32'd255);
    chk("t6_last", {28'd0, last_wr_idx_o}, 32'd11);
    step(16'h0, 16'h0, 1, 4'd11, 4'd4, 0, 16'd299, 16'd292);
    step(16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    // Reset while a read is in flight: the pulse must vanish at once
    rd_en_i = 1'b1; src_reg1_i = 4'd2; src_reg2_i = 4'd9;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_mid_cnt", {24'd0, wr_count_o}, 32'd0);
    rd_en_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < 16; r += 2)
      step(16'h0, 16'h0, 1, 4'(r), 4'(r + 1), 0, 16'h0, 16'h0);
    repeat (3) step(16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 16'h0, 16'h0);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
